// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C target states, bus levels and command bit positions
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RACK      = 4'd8,
    ST_IGNORE    = 4'd9
  } state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // Command word bit positions shared with the initiator.
  localparam int CMD_START_BIT = 0;
  localparam int CMD_WRITE_BIT = 1;
  localparam int CMD_READ_BIT  = 2;
  localparam int CMD_STOP_BIT  = 3;
  localparam int CMD_ACK_BIT   = 4;
  localparam int CMD_WIDTH     = 5;

endpackage

// File: rtl/i2c_target_regs_if.sv
// rtl/i2c_target_regs_if.sv - single-cycle register port between the I2C target and a register file
interface i2c_target_regs_if;
  logic [7:0] reg_addr;
  logic [7:0] reg_wr_data;
  logic       reg_wr_en;
  logic       reg_rd_req;
  logic [7:0] reg_rd_data;
  logic       busy;

  modport master (
    output reg_addr, reg_wr_data, reg_wr_en, reg_rd_req, busy,
    input  reg_rd_data
  );

  modport slave (
    input  reg_addr, reg_wr_data, reg_wr_en, reg_rd_req, busy,
    output reg_rd_data
  );
endinterface

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - SCL/SDA synchronizers with edge, START and STOP pulse generation
module i2c_line_sync (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);
  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       r_scl_hist;
  logic       r_sda_hist;

  // Lines reset to the idle-high level so releasing reset never fakes an edge.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_hist <= 1'b1;
      r_sda_hist <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], i_scl};
      r_sda_sync <= {r_sda_sync[0], i_sda};
      r_scl_hist <= r_scl_sync[1];
      r_sda_hist <= r_sda_sync[1];
    end
  end

  assign o_sda      = r_sda_sync[1];
  assign o_scl_rise = r_scl_sync[1] & ~r_scl_hist;
  assign o_scl_fall = ~r_scl_sync[1] & r_scl_hist;
  assign o_start    = r_scl_sync[1] & r_scl_hist & r_sda_hist & ~r_sda_sync[1];
  assign o_stop     = r_scl_sync[1] & r_scl_hist & ~r_sda_hist & r_sda_sync[1];
endmodule

// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - I2C target bridging address/pointer/data bytes onto a register port
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEVICE_ID = 7'h48
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               scl,
  inout  wire                sda,
  i2c_target_regs_if.master  bus
);
  logic w_sda;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_shift;
  logic [3:0] r_bit_cnt;
  logic [7:0] r_reg_addr;
  logic [7:0] r_wr_data;
  logic       r_wr_en;
  logic       r_rd_req;
  logic       r_load;
  logic       r_sda_low;
  logic       r_rw;
  logic       r_busy;

  logic [7:0] w_byte;
  logic       w_last_rise;
  logic       w_match;

  i2c_line_sync u_line_sync (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .i_scl      (scl),
    .i_sda      (sda),
    .o_sda      (w_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  assign sda         = r_sda_low ? 1'b0 : 1'bz;
  assign w_byte      = {r_shift[6:0], w_sda};
  assign w_last_rise = w_scl_rise && (r_bit_cnt == 4'd7);
  assign w_match     = (w_byte[7:1] == DEVICE_ID);

  assign bus.reg_addr    = r_reg_addr;
  assign bus.reg_wr_data = r_wr_data;
  assign bus.reg_wr_en   = r_wr_en;
  assign bus.reg_rd_req  = r_rd_req;
  assign bus.busy        = r_busy;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) r_state <= ST_IDLE;
    else            r_state <= w_next_state;
  end

  // ACK states use r_sda_low to tell the fall after bit 8 from the one after bit 9.
  always_comb begin
    w_next_state = r_state;
    if (w_stop) begin
      w_next_state = ST_IDLE;
    end else if (w_start) begin
      w_next_state = ST_ADDR;
    end else begin
      case (r_state)
        ST_ADDR:      if (w_last_rise) w_next_state = w_match ? ST_ADDR_ACK : ST_IGNORE;
        ST_ADDR_ACK:  if (w_scl_fall && r_sda_low) w_next_state = r_rw ? ST_RDATA : ST_PTR;
        ST_PTR:       if (w_last_rise) w_next_state = ST_PTR_ACK;
        ST_PTR_ACK:   if (w_scl_fall && r_sda_low) w_next_state = ST_WDATA;
        ST_WDATA:     if (w_last_rise) w_next_state = ST_WDATA_ACK;
        ST_WDATA_ACK: if (w_scl_fall && r_sda_low) w_next_state = ST_WDATA;
        ST_RDATA:     if (w_scl_fall && (r_bit_cnt == 4'd8)) w_next_state = ST_RACK;
        ST_RACK:      if (w_scl_rise) w_next_state = (w_sda == I2C_NACK) ? ST_IGNORE : ST_RDATA;
        default:      w_next_state = r_state;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_shift    <= 8'h00;
      r_bit_cnt  <= 4'd0;
      r_reg_addr <= 8'h00;
      r_wr_data  <= 8'h00;
      r_wr_en    <= 1'b0;
      r_rd_req   <= 1'b0;
      r_load     <= 1'b0;
      r_sda_low  <= 1'b0;
      r_rw       <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_wr_en  <= 1'b0;
      r_rd_req <= 1'b0;
      r_load   <= r_rd_req;
      if (r_load) r_shift <= bus.reg_rd_data;

      if (w_stop) begin
        r_sda_low <= 1'b0;
        r_busy    <= 1'b0;
        r_bit_cnt <= 4'd0;
      end else if (w_start) begin
        r_sda_low <= 1'b0;
        r_bit_cnt <= 4'd0;
      end else begin
        case (r_state)
          ST_ADDR: if (w_scl_rise) begin
            r_shift   <= w_byte;
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) begin
              r_rw   <= w_sda;
              r_busy <= w_match;
            end
          end
          ST_ADDR_ACK: begin
            // Read data is fetched during the ACK clock so bit 7 is ready on its falling edge.
            if (w_scl_rise && r_sda_low && r_rw) r_rd_req <= 1'b1;
            if (w_scl_fall) begin
              if (!r_sda_low) begin
                r_sda_low <= 1'b1;
              end else begin
                r_bit_cnt <= 4'd0;
                if (r_rw) begin
                  r_sda_low <= ~r_shift[7];
                  r_shift   <= {r_shift[6:0], 1'b0};
                end else begin
                  r_sda_low <= 1'b0;
                end
              end
            end
          end
          ST_PTR: if (w_scl_rise) begin
            r_shift   <= w_byte;
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) r_reg_addr <= w_byte;
          end
          ST_PTR_ACK: if (w_scl_fall) begin
            r_sda_low <= ~r_sda_low;
            if (r_sda_low) r_bit_cnt <= 4'd0;
          end
          ST_WDATA: if (w_scl_rise) begin
            r_shift   <= w_byte;
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) begin
              r_wr_data <= w_byte;
              r_wr_en   <= 1'b1;
            end
          end
          ST_WDATA_ACK: if (w_scl_fall) begin
            r_sda_low <= ~r_sda_low;
            if (r_sda_low) begin
              r_bit_cnt  <= 4'd0;
              r_reg_addr <= r_reg_addr + 8'd1;
            end
          end
          ST_RDATA: begin
            if (w_scl_rise) r_bit_cnt <= r_bit_cnt + 4'd1;
            if (w_scl_fall) begin
              if (r_bit_cnt < 4'd8) begin
                r_sda_low <= ~r_shift[7];
                r_shift   <= {r_shift[6:0], 1'b0};
              end else begin
                r_sda_low <= 1'b0;
              end
            end
          end
          ST_RACK: if (w_scl_rise) begin
            if (w_sda == I2C_ACK) begin
              r_reg_addr <= r_reg_addr + 8'd1;
              r_rd_req   <= 1'b1;
              r_bit_cnt  <= 4'd0;
            end else begin
              r_busy <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_target_regs.sv
// tb/tb_i2c_target_regs.sv - bit-banged I2C initiator with a register-file model and write scoreboard
module tb_i2c_target_regs;
  import i2c_pkg::*;

  localparam int Q = 8;

  logic sys_clk    = 1'b0;
  logic sys_rst_n  = 1'b0;
  logic scl        = 1'b1;
  logic tb_sda_low = 1'b0;
  wire  sda;

  pullup (sda);
  assign sda = tb_sda_low ? 1'b0 : 1'bz;

  i2c_target_regs_if u_bus ();

  i2c_target_regs #(.DEVICE_ID(7'h48)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .scl       (scl),
    .sda       (sda),
    .bus       (u_bus)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    if (!sys_rst_n)              u_bus.reg_rd_data <= 8'h00;
    else if (u_bus.reg_rd_req)   u_bus.reg_rd_data <= u_bus.reg_addr ^ 8'hFF;
  end

  logic [7:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  int n_low_seen  = 0;
  int n_busy_seen = 0;

  always @(posedge sys_clk) begin
    if (u_bus.reg_wr_en) begin
      wr_addr_q.push_back(u_bus.reg_addr);
      wr_data_q.push_back(u_bus.reg_wr_data);
    end
    if (!tb_sda_low && sda === 1'b0) n_low_seen++;
    if (u_bus.busy === 1'b1) n_busy_seen++;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int wr_idx   = 0;
  logic [7:0] m_ptr = 8'h00;
  logic [7:0] wbuf [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wq();
    repeat (Q) @(posedge sys_clk);
    #1;
  endtask

  task automatic i2c_start();
    tb_sda_low = 1'b0; wq();
    scl = 1'b1;        wq();
    tb_sda_low = 1'b1; wq();
    scl = 1'b0;        wq();
  endtask

  task automatic i2c_stop();
    tb_sda_low = 1'b1; wq();
    scl = 1'b1;        wq();
    tb_sda_low = 1'b0; wq();
    wq();
  endtask

  task automatic send_bit(input logic b);
    tb_sda_low = ~b; wq();
    scl = 1'b1;      wq(); wq();
    scl = 1'b0;      wq();
  endtask

  task automatic recv_bit(output logic b);
    tb_sda_low = 1'b0; wq();
    scl = 1'b1;        wq();
    b = sda;           wq();
    scl = 1'b0;        wq();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      recv_bit(b);
      d = {d[6:0], b};
    end
    send_bit(nack);
  endtask

  task automatic write_txn(input logic [7:0] ptr, input int n);
    logic a;
    i2c_start();
    write_byte(8'h90, a); check("wr_addr_ack", a, I2C_ACK);
    write_byte(ptr, a);   check("wr_ptr_ack", a, I2C_ACK);
    for (int i = 0; i < n; i++) begin
      write_byte(wbuf[i], a); check("wr_data_ack", a, I2C_ACK);
    end
    check("wr_busy_mid", u_bus.busy, 1'b1);
    i2c_stop();
    check("wr_strobe_count", wr_addr_q.size() - wr_idx, n);
    for (int i = 0; i < n; i++) begin
      check("wr_strobe_addr", wr_addr_q[wr_idx + i], 8'(ptr + i));
      check("wr_strobe_data", wr_data_q[wr_idx + i], wbuf[i]);
    end
    wr_idx = wr_addr_q.size();
    m_ptr  = 8'(ptr + n);
    check("wr_ptr_after", u_bus.reg_addr, m_ptr);
    check("wr_busy_after", u_bus.busy, 1'b0);
  endtask

  task automatic read_txn(input logic [7:0] ptr, input int n);
    logic a;
    logic [7:0] d;
    i2c_start();
    write_byte(8'h90, a); check("rd_addr_ack", a, I2C_ACK);
    write_byte(ptr, a);   check("rd_ptr_ack", a, I2C_ACK);
    i2c_start();
    write_byte(8'h91, a); check("rd_addr2_ack", a, I2C_ACK);
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, d);
      check("rd_byte", d, 8'(ptr + i) ^ 8'hFF);
    end
    repeat (4) @(posedge sys_clk);
    #1;
    check("rd_sda_released", sda, 1'b1);
    check("rd_state_ignore", 32'(dut.r_state), 32'(ST_IGNORE));
    check("rd_busy_ignore", u_bus.busy, 1'b0);
    i2c_stop();
    check("rd_state_idle", 32'(dut.r_state), 32'(ST_IDLE));
    check("rd_no_strobe", wr_addr_q.size(), wr_idx);
    m_ptr = 8'(ptr + n - 1);
    check("rd_ptr_after", u_bus.reg_addr, m_ptr);
  endtask

  initial begin
    logic a;
    logic [7:0] p;
    int base_low;
    int base_busy;
    int n;

    repeat (5) @(posedge sys_clk);
    #1;
    check("rst_sda", sda, 1'b1);
    check("rst_reg_addr", u_bus.reg_addr, 8'h00);
    check("rst_wr_data", u_bus.reg_wr_data, 8'h00);
    check("rst_wr_en", u_bus.reg_wr_en, 1'b0);
    check("rst_rd_req", u_bus.reg_rd_req, 1'b0);
    check("rst_busy", u_bus.busy, 1'b0);
    sys_rst_n = 1'b1;
    wq();

    wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
    write_txn(8'h10, 2);

    read_txn(8'h20, 2);

    base_low  = n_low_seen;
    base_busy = n_busy_seen;
    i2c_start();
    write_byte(8'h92, a); check("mis_addr_nack", a, I2C_NACK);
    write_byte(8'h01, a); check("mis_data_nack", a, I2C_NACK);
    i2c_stop();
    check("mis_sda_never_low", n_low_seen - base_low, 0);
    check("mis_busy_never", n_busy_seen - base_busy, 0);
    check("mis_no_strobe", wr_addr_q.size(), wr_idx);
    check("mis_ptr_kept", u_bus.reg_addr, m_ptr);

    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    write_txn(8'hFF, 2);

    p = 8'($urandom_range(0, 255));
    i2c_start();
    write_byte(8'h90, a); check("pri_addr_ack", a, I2C_ACK);
    write_byte(p, a);     check("pri_ptr_ack", a, I2C_ACK);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
    i2c_stop();
    check("pri_no_strobe", wr_addr_q.size(), wr_idx);
    check("pri_state_idle", 32'(dut.r_state), 32'(ST_IDLE));
    check("pri_ptr", u_bus.reg_addr, p);
    check("pri_busy", u_bus.busy, 1'b0);

    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(i == 7 || i == 4);
    tb_sda_low = 1'b0;
    repeat (4) @(posedge sys_clk);
    #1;
    check("rmid_ack_driven", sda, 1'b0);
    sys_rst_n = 1'b0;
    @(posedge sys_clk);
    #1;
    check("rmid_sda_released", sda, 1'b1);
    check("rmid_reg_addr", u_bus.reg_addr, 8'h00);
    check("rmid_wr_data", u_bus.reg_wr_data, 8'h00);
    check("rmid_wr_en", u_bus.reg_wr_en, 1'b0);
    check("rmid_rd_req", u_bus.reg_rd_req, 1'b0);
    check("rmid_busy", u_bus.busy, 1'b0);
    scl = 1'b1;
    wq();
    sys_rst_n = 1'b1;
    wq();
    check("rmid_no_strobe", wr_addr_q.size(), wr_idx);

    for (int t = 0; t < 3; t++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
      write_txn(8'($urandom), n);
      read_txn(8'($urandom), $urandom_range(1, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
